fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the 5-stage MIPS pipeline. It owns the PC and drives the SRAM-like instruction port (req / addr_ok / data_ok). It delivers each fetched instruction, its PC and its delay-slot flag into the IF/ID pipeline register, and generates that register's `stallD` and `flushD` controls. It applies branch redirects after the delay slot, exception redirects immediately, and discards responses that are in flight when an exception redirect arrives.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC of the first fetch after reset.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_backend` in 1: D stage must hold (load-use, mult/div busy); from the hazard unit.
- `flush_exc` in 1: exception/ERET redirect; highest priority.
- `exc_pc` in 32: redirect target, valid with `flush_exc`.
- `is_branchD` in 1: instruction in D is a branch/jump, so the next handed-off instruction is its delay slot.
- `branch_takeD` in 1: branch in D is taken; qualified by `is_branchD`.
- `branch_targetD` in 32: taken target.
- `inst_req` out 1: request valid.
- `inst_addr` out 32: request address, always equal to `pc`.
- `inst_addr_ok` in 1: address accepted this cycle.
- `inst_data_ok` in 1: read data valid this cycle.
- `inst_rdata` in 32: read data.
- `pcF`, `pcplus4F`, `instrF` out 32: to the IF/ID register.
- `is_in_delayslot_iF` out 1: to the IF/ID register.
- `stallD` out 1: hold the IF/ID register.
- `flushD` out 1: load a bubble into the IF/ID register.

## Operation
- State machine with states IDLE, REQ, WAIT and HOLD. Registers: `pc`, `instr_buf`, `discard`, `ds_pending`, `ds_taken`, `ds_target`.
- Reset:
  - `pc` = `RESET_PC`; state = IDLE.
  - All flags and `instr_buf` are 0.
  - Outputs: `inst_req`=0, `flushD`=1, `stallD`=0, `is_in_delayslot_iF`=0.
  - `pcF` = `RESET_PC`, `pcplus4F` = `RESET_PC`+4, `instrF`=0.
- IDLE: go to REQ on the next cycle.
- REQ:
  - `inst_req`=1.
  - On `inst_addr_ok` go to WAIT.
  - The address may change while not yet accepted.
- WAIT:
  - `inst_req`=0.
  - On `inst_data_ok` with `discard`=1: clear `discard` and go to REQ. The data is dropped.
  - On `inst_data_ok` with `discard`=0: `instr_buf` <= `inst_rdata`, go to HOLD.
- HOLD:
  - `instrF`=`instr_buf`, `pcF`=`pc`.
  - A handoff occurs when `stall_backend`=0; then go to REQ with the next PC.
  - Otherwise stay in HOLD.
- Handoff cycle outputs: `flushD`=0, `stallD`=0.
- Non-handoff cycle outputs:
  - `stallD` = `stall_backend` & ~`flush_exc`.
  - `flushD` = `flush_exc` | ~`stall_backend`, which inserts a bubble.
- Next PC on handoff, in priority order:
  - `is_branchD`&`branch_takeD`: `branch_targetD`.
  - `ds_pending`&`ds_taken`: `ds_target`.
  - Otherwise: `pc`+4.
  - All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `is_in_delayslot_iF` = handoff & (`is_branchD` | `ds_pending`).
- Pending delay slot:
  - Set when `is_branchD` & ~`stall_backend` & no handoff, i.e. the branch leaves D before its delay slot arrives.
  - On set, capture `ds_taken`=`branch_takeD` and `ds_target`=`branch_targetD`.
  - Cleared on handoff or `flush_exc`.
- `flush_exc` overrides everything else in the same cycle:
  - `pc` <= `exc_pc`; `ds_pending` <= 0.
  - No handoff occurs.
  - From REQ or HOLD: go to REQ.
  - From WAIT: set `discard` and stay in WAIT, unless `inst_data_ok` is also high that cycle. In that case the data is dropped and the next state is REQ.
  - From REQ when `inst_addr_ok` is also high: the accepted transaction is stale. Go to WAIT with `discard`=1.
- Simultaneous branch in D and `flush_exc`: the exception wins; the branch redirect is lost.
- `rst` mid-transaction: return to IDLE immediately. Any late `inst_data_ok` arriving in IDLE or REQ is ignored.

## Timing
- Without `FETCH_BYPASS_EN`, the minimum is 3 cycles per instruction: REQ(addr_ok) → WAIT(data_ok) → HOLD(handoff).
- `inst_req` rises 1 cycle after `rst` is released.
- The IF/ID register captures `instrF` on the edge that ends the handoff cycle.
- Redirect latency: the first request to `exc_pc` is issued the cycle after `flush_exc`, unless a discard is pending.
- At most one transaction is outstanding. `inst_req` is never high in WAIT.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - In WAIT, `inst_data_ok` & ~`discard` & ~`stall_backend` & ~`flush_exc` hands off directly.
  - `instrF` = `inst_rdata` and the next state is REQ, skipping HOLD.
  - Minimum 2 cycles per instruction.
  - If `stall_backend`=1, HOLD is used as normal.
- Undefined: data always passes through `instr_buf`/HOLD. This keeps `inst_rdata` off the paths to `instrF`, `flushD` and `stallD`.

## Test plan
- Reset release, zero-wait memory (addr_ok and data_ok each 1 cycle after request) → handoffs at PCs 0xBFC00000, 0xBFC00004, 0xBFC00008. With bypass, handoffs occur every 3 cycles without and every 2 cycles with.
- `stall_backend` high for 4 cycles while in HOLD → `stallD`=1 and `instrF` stable for 4 cycles, handoff on the 5th cycle, no instruction lost or duplicated.
- Branch at 0xBFC00010 taken to 0xBFC00100, delay slot fetched late → `ds_pending` set. The delay-slot handoff has `is_in_delayslot_iF`=1, and the next request is to 0xBFC00100.
- `flush_exc` with `exc_pc`=0xBFC00380 while in WAIT; data_ok 3 cycles later → that data is never handed off. The next request is to 0xBFC00380, and `flushD`=1 throughout.
- `flush_exc` coincident with `inst_addr_ok` in REQ → `discard` set, the stale response is dropped, and the refetch goes to `exc_pc`.
- `rst` asserted in WAIT, then data_ok arrives → no handoff, and the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-side SRAM-like port between the fetch sequencer and instruction memory.
interface fetch_ctrl_if;
    localparam int unsigned XW = 32;

    logic          inst_req;
    logic [XW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [XW-1:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction port and feeds the IF/ID register.
// Optional FETCH_BYPASS_EN: hand off read data straight from the port, skipping HOLD.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_ctrl_if.master       inst,
    input  logic               stall_backend,
    input  logic               flush_exc,
    input  logic [31:0]        exc_pc,
    input  logic               is_branchD,
    input  logic               branch_takeD,
    input  logic [31:0]        branch_targetD,
    output logic [31:0]        pcF,
    output logic [31:0]        pcplus4F,
    output logic [31:0]        instrF,
    output logic               is_in_delayslot_iF,
    output logic               stallD,
    output logic               flushD
);
    localparam int unsigned XW = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]    state,      state_d;
    logic [XW-1:0] pc,         pc_d;
    logic [XW-1:0] instr_buf,  instr_buf_d;
    logic          discard,    discard_d;
    logic          ds_pending, ds_pending_d;
    logic          ds_taken,   ds_taken_d;
    logic [XW-1:0] ds_target,  ds_target_d;
    logic          handoff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            instr_buf  <= '0;
            discard    <= 1'b0;
            ds_pending <= 1'b0;
            ds_taken   <= 1'b0;
            ds_target  <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            instr_buf  <= instr_buf_d;
            discard    <= discard_d;
            ds_pending <= ds_pending_d;
            ds_taken   <= ds_taken_d;
            ds_target  <= ds_target_d;
        end
    end

    always_comb begin
        state_d        = state;
        pc_d           = pc;
        instr_buf_d    = instr_buf;
        discard_d      = discard;
        ds_pending_d   = ds_pending;
        ds_taken_d     = ds_taken;
        ds_target_d    = ds_target;
        handoff        = 1'b0;
        inst.inst_req  = (state == S_REQ);
        inst.inst_addr = pc;
        pcF            = pc;
        pcplus4F       = pc + XW'(4);
        instrF         = instr_buf;

        if (flush_exc) begin
            // Exception redirect: an accepted or in-flight response becomes stale.
            pc_d         = exc_pc;
            ds_pending_d = 1'b0;
            case (state)
                S_REQ: begin
                    if (inst.inst_addr_ok) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (inst.inst_data_ok) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (inst.inst_addr_ok) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (inst.inst_data_ok) begin
                        if (discard) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end
`ifdef FETCH_BYPASS_EN
                        else if (!stall_backend) begin
                            handoff = 1'b1;
                            instrF  = inst.inst_rdata;
                            state_d = S_REQ;
                        end
`endif
                        else begin
                            instr_buf_d = inst.inst_rdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall_backend) begin
                        handoff = 1'b1;
                        state_d = S_REQ;
                    end
                end
            endcase

            // Branch redirect takes effect after the delay slot is handed off.
            if (handoff) begin
                ds_pending_d = 1'b0;
                if (is_branchD && branch_takeD)  pc_d = branch_targetD;
                else if (ds_pending && ds_taken) pc_d = ds_target;
                else                             pc_d = pc + XW'(4);
            end else if (is_branchD && !stall_backend) begin
                ds_pending_d = 1'b1;
                ds_taken_d   = branch_takeD;
                ds_target_d  = branch_targetD;
            end
        end

        stallD             = handoff ? 1'b0 : (stall_backend & ~flush_exc);
        flushD             = handoff ? 1'b0 : (flush_exc | ~stall_backend);
        is_in_delayslot_iF = handoff & (is_branchD | ds_pending);
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory responder, handoff-level model and literal checkpoints.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef FETCH_BYPASS_EN
    localparam int HO_LAT = 1;
`else
    localparam int HO_LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        stall_backend, flush_exc, is_branchD, branch_takeD;
    logic [31:0] exc_pc, branch_targetD;
    logic [31:0] pcF, pcplus4F, instrF;
    logic        is_in_delayslot_iF, stallD, flushD;

    fetch_ctrl_if ibus();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .inst(ibus),
        .stall_backend(stall_backend), .flush_exc(flush_exc), .exc_pc(exc_pc),
        .is_branchD(is_branchD), .branch_takeD(branch_takeD), .branch_targetD(branch_targetD),
        .pcF(pcF), .pcplus4F(pcplus4F), .instrF(instrF),
        .is_in_delayslot_iF(is_in_delayslot_iF), .stallD(stallD), .flushD(flushD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: content of address a is ~a; responds one request at a time.
    int          data_lat = 0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    initial begin
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
        ibus.inst_rdata   = '0;
    end
    always @(negedge clk) begin
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_data_ok = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                ibus.inst_data_ok = 1'b1;
                ibus.inst_rdata   = ~m_addr;
                m_busy            = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (ibus.inst_req === 1'b1) begin
            ibus.inst_addr_ok = 1'b1;
            m_busy = 1'b1;
            m_addr = ibus.inst_addr;
            m_cnt  = data_lat;
        end
    end

    // Architectural model: which PC must be fetched/handed off next.
    logic [31:0] m_next = RESET_PC;
    bit          m_pend = 1'b0;
    bit          m_ptaken = 1'b0;
    logic [31:0] m_ptarget = '0;
    bit          ho;
    int          ho_cyc[$];
    logic [31:0] ho_pc[$];
    bit          ho_ds[$];

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            m_next = RESET_PC;
            m_pend = 1'b0;
        end else begin
            ho = (flushD === 1'b0) && (stallD === 1'b0);
            check("pcplus4F", pcplus4F, pcF + 32'd4);
            if (ibus.inst_req === 1'b1) check("inst_addr", ibus.inst_addr, m_next);
            if (ho) begin
                check("ho_legal", {30'd0, flush_exc, stall_backend}, 32'd0);
                check("ho_pcF", pcF, m_next);
                check("ho_instrF", instrF, ~m_next);
                check("ho_ds", {31'd0, is_in_delayslot_iF}, {31'd0, is_branchD | m_pend});
                ho_cyc.push_back(cyc);
                ho_pc.push_back(pcF);
                ho_ds.push_back(is_in_delayslot_iF);
                if (is_branchD && branch_takeD) m_next = branch_targetD;
                else if (m_pend && m_ptaken)    m_next = m_ptarget;
                else                            m_next = m_next + 32'd4;
                m_pend = 1'b0;
            end else begin
                check("stallD", {31'd0, stallD}, {31'd0, stall_backend & ~flush_exc});
                check("flushD", {31'd0, flushD}, {31'd0, flush_exc | ~stall_backend});
                check("ds_idle", {31'd0, is_in_delayslot_iF}, 32'd0);
                if (flush_exc) begin
                    m_next = exc_pc;
                    m_pend = 1'b0;
                end else if (is_branchD && !stall_backend) begin
                    m_pend    = 1'b1;
                    m_ptaken  = branch_takeD;
                    m_ptarget = branch_targetD;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ho(input int n);
        int k = 0;
        while (ho_pc.size() < n && k < 60) begin
            step(1);
            k++;
        end
        if (ho_pc.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_ho: got %0d handoffs, expected %0d", ho_pc.size(), n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'd0, ibus.inst_req}, 32'd0);
        check({tag, "_flushD"}, {31'd0, flushD}, 32'd1);
        check({tag, "_stallD"}, {31'd0, stallD}, 32'd0);
        check({tag, "_ds"}, {31'd0, is_in_delayslot_iF}, 32'd0);
        check({tag, "_pcF"}, pcF, 32'hBFC0_0000);
        check({tag, "_pcplus4F"}, pcplus4F, 32'hBFC0_0004);
        check({tag, "_instrF"}, instrF, 32'd0);
    endtask

    int rel, h;

    initial begin
        rst = 1'b1; stall_backend = 1'b0; flush_exc = 1'b0; exc_pc = '0;
        is_branchD = 1'b0; branch_takeD = 1'b0; branch_targetD = '0;

        // Reset release and back-to-back fetch with zero-wait memory.
        step(3);
        check_reset_outputs("rst0");
        rst = 1'b0;
        rel = cyc;
        step(1);
        check("t1_req_rise", {31'd0, ibus.inst_req}, 32'd1);
        wait_ho(3);
        check("t1_pc0", ho_pc[0], 32'hBFC0_0000);
        check("t1_pc1", ho_pc[1], 32'hBFC0_0004);
        check("t1_pc2", ho_pc[2], 32'hBFC0_0008);
        check("t1_cyc0", 32'(ho_cyc[0]), 32'(rel + 1 + HO_LAT));
        check("t1_cyc2", 32'(ho_cyc[2]), 32'(rel + 1 + HO_LAT + 2 * (HO_LAT + 1)));

        // Backend stall: instruction held, handed off once the stall drops.
        h = ho_cyc[2];
        stall_backend = 1'b1;
        step(6);
        stall_backend = 1'b0;
        wait_ho(4);
        check("t2_pc", ho_pc[3], 32'hBFC0_000C);
        check("t2_cyc", 32'(ho_cyc[3]), 32'(h + 7));

        // Taken branch whose delay slot arrives late.
        wait_ho(5);
        check("t3_br_pc", ho_pc[4], 32'hBFC0_0010);
        is_branchD = 1'b1; branch_takeD = 1'b1; branch_targetD = 32'hBFC0_0100;
        step(1);
        is_branchD = 1'b0; branch_takeD = 1'b0; branch_targetD = '0;
        wait_ho(6);
        check("t3_ds_pc", ho_pc[5], 32'hBFC0_0014);
        check("t3_ds_flag", {31'd0, ho_ds[5]}, 32'd1);
        check("t3_next_req", {ibus.inst_addr[31:1], ibus.inst_req}, 32'hBFC0_0101);
        wait_ho(7);
        check("t3_tgt_pc", ho_pc[6], 32'hBFC0_0100);
        check("t3_tgt_ds", {31'd0, ho_ds[6]}, 32'd0);

        // Exception while waiting for data; late response must be dropped.
        h = ho_cyc[6];
        data_lat = 3;
        step(1);
        flush_exc = 1'b1; exc_pc = 32'hBFC0_0380;
        step(1);
        flush_exc = 1'b0; data_lat = 0;
        step(3);
        check("t4_refetch", {ibus.inst_addr[31:1], ibus.inst_req}, 32'hBFC0_0381);
        check("t4_no_ho", 32'(ho_pc.size()), 32'd7);
        wait_ho(8);
        check("t4_pc", ho_pc[7], 32'hBFC0_0380);
        check("t4_cyc", 32'(ho_cyc[7]), 32'(h + 6 + HO_LAT));

        // Exception coincident with address acceptance.
        h = ho_cyc[7];
        flush_exc = 1'b1; exc_pc = 32'hBFC0_0200;
        step(1);
        flush_exc = 1'b0;
        step(1);
        check("t5_refetch", {ibus.inst_addr[31:1], ibus.inst_req}, 32'hBFC0_0201);
        wait_ho(9);
        check("t5_pc", ho_pc[8], 32'hBFC0_0200);
        check("t5_cyc", 32'(ho_cyc[8]), 32'(h + 3 + HO_LAT));

        // Reset while waiting; the late response arrives in REQ and is ignored.
        h = ho_cyc[8];
        data_lat = 3;
        step(1);
        rst = 1'b1; data_lat = 0;
        step(1);
        rst = 1'b0;
        check_reset_outputs("rst1");
        wait_ho(10);
        check("t6_pc", ho_pc[9], 32'hBFC0_0000);
        check("t6_cyc", 32'(ho_cyc[9]), 32'(h + 6 + HO_LAT));

        // Exception beats a simultaneous taken branch; PC wraps past the top.
        flush_exc = 1'b1; exc_pc = 32'hFFFF_FFFC;
        is_branchD = 1'b1; branch_takeD = 1'b1; branch_targetD = 32'h1234_0000;
        step(1);
        flush_exc = 1'b0; is_branchD = 1'b0; branch_takeD = 1'b0;
        wait_ho(11);
        check("t7_pc", ho_pc[10], 32'hFFFF_FFFC);
        check("t7_ds", {31'd0, ho_ds[10]}, 32'd0);
        wait_ho(12);
        check("t7_wrap", ho_pc[11], 32'h0000_0000);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
